// File: rtl/fp8_result_drain.sv
// rtl/fp8_result_drain.sv - captures an N_OUT-byte FP8 vector and drains it one byte per handshake
// Optional second (pending) bank compiled in with FP8_DRAIN_PINGPONG_EN.
module fp8_result_drain #(
  parameter int N_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [8*N_OUT-1:0] load_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_last,
  output logic               busy
);
  localparam int IW = $clog2(N_OUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [8*N_OUT-1:0] data_q, data_d;
  logic               load_hs, out_hs, last_hs;
`ifdef FP8_DRAIN_PINGPONG_EN
  logic [8*N_OUT-1:0] pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      data_q      <= '0;
`ifdef FP8_DRAIN_PINGPONG_EN
      pend_q      <= '0;
      pend_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
`ifdef FP8_DRAIN_PINGPONG_EN
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
`endif
    end
  end

  always_comb begin
    out_valid = (state_q == DRAIN);
    out_last  = out_valid && (idx_q == LAST_IDX);
    out_data  = out_valid ? data_q[{idx_q, 3'b000} +: 8] : 8'h00;
    out_hs    = out_valid & out_ready;
    last_hs   = out_hs & out_last;
`ifdef FP8_DRAIN_PINGPONG_EN
    load_ready = !pend_full_q;
    busy       = out_valid | pend_full_q;
`else
    load_ready = (state_q == IDLE) | last_hs;
    busy       = out_valid;
`endif
    load_hs = load_valid & load_ready;

    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef FP8_DRAIN_PINGPONG_EN
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
`endif

    if (out_hs) begin
      idx_d = out_last ? '0 : idx_q + IW'(1);
    end

    if (state_q == IDLE) begin
      if (load_hs) begin
        data_d  = load_data;
        idx_d   = '0;
        state_d = DRAIN;
      end
    end else if (last_hs) begin
      // Refill the active bank at the last-byte edge so the next vector follows without a bubble.
`ifdef FP8_DRAIN_PINGPONG_EN
      if (pend_full_q) begin
        data_d      = pend_q;
        pend_full_d = 1'b0;
      end else if (load_hs) begin
        data_d = load_data;
      end else begin
        state_d = IDLE;
      end
`else
      if (load_hs) begin
        data_d = load_data;
      end else begin
        state_d = IDLE;
      end
`endif
    end
`ifdef FP8_DRAIN_PINGPONG_EN
    else if (load_hs) begin
      pend_d      = load_data;
      pend_full_d = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_fp8_result_drain.sv
// tb/tb_fp8_result_drain.sv - table, directed and random checks of fp8_result_drain against a byte-queue model
module tb_fp8_result_drain;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [8*N-1:0] load_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [7:0]     out_data;
  logic           out_last;
  logic           busy;

  always #5 clk = ~clk;

  fp8_result_drain #(.N_OUT(N)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int cyc = 0;

  // Reference: every accepted byte queued as {is_last, byte}; out_valid whenever bytes remain.
  logic [8:0] q[$];
  logic [7:0] log_q[$];
  int         hs_cyc[$];
  logic       cur_lhs, cur_ohs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic lv, input logic [8*N-1:0] ld, input logic ordy, input logic r);
    logic exp_valid, exp_ready;
    load_valid = lv;
    load_data  = ld;
    out_ready  = ordy;
    rst        = r;
    #1;
    exp_valid = (q.size() > 0);
`ifdef FP8_DRAIN_PINGPONG_EN
    exp_ready = (q.size() <= N);
`else
    exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
`endif
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("out_data", 32'(out_data), exp_valid ? 32'(q[0][7:0]) : 32'h0);
      chk("out_last", 32'(out_last), exp_valid ? 32'(q[0][8]) : 32'h0);
      chk("busy", 32'(busy), 32'(exp_valid));
      chk("load_ready", 32'(load_ready), 32'(exp_ready));
    end
    cur_lhs = lv & exp_ready & !r;
    cur_ohs = exp_valid & ordy & !r;
    if (cur_ohs) begin
      log_q.push_back(out_data);
      hs_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (cur_ohs) void'(q.pop_front());
      if (cur_lhs)
        for (int k = 0; k < N; k++) q.push_back({(k == N - 1), ld[8*k +: 8]});
    end
    cyc++;
    #1;
  endtask

  task automatic flush(input string name);
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk(name, q.size(), 0);
  endtask

  task automatic clear_log();
    log_q.delete();
    hs_cyc.delete();
  endtask

  typedef struct {
    logic [31:0] ld;
    int          stall_at;
    int          stall_len;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[4];

  initial begin
    logic [31:0] e;
    int          stalled;
    bit          acc;

    tv[0] = '{32'h44332211, -1, 0, 32'h11223344};
    tv[1] = '{32'h44332211,  1, 3, 32'h11223344};
    tv[2] = '{32'h80FF7F00,  0, 2, 32'h007FFF80};
    tv[3] = '{32'hDEADBEEF,  3, 5, 32'hEFBEADDE};

    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk_en = 1;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("reset_out_data", 32'(out_data), 32'h0);

    // Table: single vector, optional stall on one element, then drain order check.
    for (int i = 0; i < 4; i++) begin
      clear_log();
      step(1'b1, tv[i].ld, 1'b1, 1'b0);
      stalled = 0;
      for (int c = 0; c < 30 && q.size() > 0; c++) begin
        if (log_q.size() == tv[i].stall_at && stalled < tv[i].stall_len) begin
          stalled++;
          step(1'b0, '0, 1'b0, 1'b0);
        end else begin
          step(1'b0, '0, 1'b1, 1'b0);
        end
      end
      chk("tbl_drained", q.size(), 0);
      chk("tbl_count", log_q.size(), N);
      e = tv[i].exp;
      for (int k = 0; k < N && k < log_q.size(); k++)
        chk("tbl_byte", 32'(log_q[k]), 32'(e[31-8*k -: 8]));
      chk("tbl_busy_after", 32'(busy), 32'h0);
    end

    // Back-to-back: second vector offered continuously, 8 bytes gap-free.
    clear_log();
    step(1'b1, 32'h44332211, 1'b1, 1'b0);
    acc = 0;
    for (int c = 0; c < 12 && !acc; c++) begin
      step(1'b1, 32'h88776655, 1'b1, 1'b0);
      acc = cur_lhs;
    end
    chk("b2b_accepted", 32'(acc), 32'h1);
    flush("b2b_flush");
    chk("b2b_count", log_q.size(), 8);
    if (hs_cyc.size() == 8) chk("b2b_span", hs_cyc[7] - hs_cyc[0] + 1, 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++)
      chk("b2b_byte", 32'(log_q[k]), 32'(8'h11 * (k + 1)));

    // Reset mid-drain with simultaneous handshakes; stale bytes must never appear.
    clear_log();
    step(1'b1, 32'h44332211, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h99999999, 1'b1, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    clear_log();
    step(1'b1, 32'hDDCCBBAA, 1'b1, 1'b0);
    flush("rst_flush");
    chk("rst_count", log_q.size(), N);
    for (int k = 0; k < N && k < log_q.size(); k++)
      chk("rst_byte", 32'(log_q[k]), 32'(8'hAA + 8'h11 * k));

    // Second load during a stalled drain: pending bank takes it, or load is held off.
    clear_log();
    step(1'b1, 32'h44332211, 1'b0, 1'b0);
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 32'h88776655, 1'b0, 1'b0);
      acc = acc | cur_lhs;
    end
`ifdef FP8_DRAIN_PINGPONG_EN
    chk("pp_accepted", 32'(acc), 32'h1);
    chk("pp_ready_low", 32'(load_ready), 32'h0);
`else
    chk("np_held_off", 32'(acc), 32'h0);
    chk("np_ready_low", 32'(load_ready), 32'h0);
`endif
    for (int c = 0; c < 12 && !acc; c++) begin
      step(1'b1, 32'h88776655, 1'b1, 1'b0);
      acc = cur_lhs;
    end
    flush("pp_flush");
    chk("pp_count", log_q.size(), 8);
    if (hs_cyc.size() == 8) chk("pp_span", hs_cyc[7] - hs_cyc[0] + 1, 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++)
      chk("pp_byte", 32'(log_q[k]), 32'(8'h11 * (k + 1)));

    // Random traffic including occasional resets.
    for (int c = 0; c < 800; c++)
      step(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 99) == 0));
    flush("rand_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp8_result_drain.md
FP8_RESULT_DRAIN -- requirements
Module: fp8_result_drain

Interface
REQ-001 SHALL have parameter N_OUT, default 4, number of FP8 results per captured vector (legal range 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load_valid  input  1  upstream FP8 result vector present.
REQ-005 SHALL have port load_ready  output  1  block accepts load_data this cycle.
REQ-006 SHALL have port load_data  input  8*N_OUT  FP8 vector; element i at bits [8i+7:8i].
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid FP8 byte.
REQ-008 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-009 SHALL have port out_data  output  8  current FP8 byte {sign, exp[3:0], mant[2:0]}, passed unmodified.
REQ-010 SHALL have port out_last  output  1  high with out_valid on element N_OUT-1 only.
REQ-011 SHALL have port busy  output  1  high whenever any captured data is not yet drained.

Function
REQ-012 SHALL capture load_data into the active bank on a load handshake (load_valid & load_ready at a clk edge).
REQ-013 SHALL use a two-state FSM for the active bank: IDLE (empty) and DRAIN (holding data).
REQ-014 SHALL transition IDLE->DRAIN on load handshake; DRAIN->IDLE on the output handshake of element N_OUT-1 unless a new vector is captured or promoted in the same edge, in which case it stays in DRAIN.
REQ-015 SHALL assert out_valid in the cycle after capture, presenting element 0 (latency 1 cycle).
REQ-016 SHALL emit elements in ascending order 0..N_OUT-1, one per output handshake (out_valid & out_ready).
REQ-017 SHALL hold out_data, out_last and out_valid stable while out_valid & !out_ready.
REQ-018 SHALL keep a $clog2(N_OUT)-bit element index, incremented per output handshake, wrapping to 0 after element N_OUT-1.
REQ-019 SHALL sustain one byte per cycle under continuous out_ready, with no bubble between consecutive vectors when the next vector is available.
REQ-020 SHALL ignore load_data when load_ready is low; out_ready while out_valid is low SHALL have no effect.
REQ-021 SHALL drive busy = (active bank in DRAIN) | (pending bank full, when present).

Reset
REQ-022 SHALL, on rst high at a clk edge, force FSM to IDLE, index to 0, pending bank empty, regardless of in-progress drain or simultaneous handshakes.
REQ-023 SHALL drive during and after reset: out_valid=0, out_last=0, out_data=8'h00, busy=0, load_ready=1 from the first cycle after rst deasserts.
REQ-024 SHALL discard all captured but undrained bytes on reset; none SHALL appear after reset.

Configuration
REQ-025 SHALL compile a second (pending) bank only when macro FP8_DRAIN_PINGPONG_EN is defined.
REQ-026 Without FP8_DRAIN_PINGPONG_EN: load_ready = IDLE | (output handshake on element N_OUT-1 this cycle); capture in that cycle loads the active bank directly.
REQ-027 With FP8_DRAIN_PINGPONG_EN: load_ready = !pending_full (registered); capture during DRAIN fills the pending bank; capture in IDLE with pending empty fills the active bank.
REQ-028 With FP8_DRAIN_PINGPONG_EN, on the last-element handshake with pending full, pending SHALL be promoted to active at that edge, index 0, pending cleared; element 0 of the promoted vector appears the next cycle.
REQ-029 Port list and drain order SHALL be identical in both builds.

Verification (N_OUT=4)
REQ-030 Basic: load 32'h44332211, out_ready=1 -> out_data 11,22,33,44 on 4 consecutive cycles starting 1 cycle after capture, out_last only with 44, then busy=0.
REQ-031 Backpressure: same load, out_ready low 3 cycles on element 1 -> out_data held at 22 with out_valid=1, then 33,44 follow; no byte dropped or repeated.
REQ-032 Back-to-back: loads 32'h44332211 then 32'h88776655 offered continuously, out_ready=1 -> 8 bytes 11..44,55..88 on 8 consecutive cycles, out_last on 44 and 88.
REQ-033 Reset mid-drain: rst pulsed after byte 22 consumed -> out_valid=0, out_data=00 next cycle; 33/44 never appear; new load 32'hDDCCBBAA drains AA,BB,CC,DD.
REQ-034 Pingpong (FP8_DRAIN_PINGPONG_EN): load 32'h44332211, load 32'h88776655 during drain, out_ready=0 -> load_ready=0 after second capture; releasing out_ready yields 11..88 gap-free. Without macro, second load held off until last-byte handshake.
